// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM stage: width defaults, memory FSM states and
// the packed instruction-control bundle carried through the M register.
package ex_mem_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_REG_W  = 4;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic is_branch;
    logic is_jal;
    logic is_load;
    logic is_store;
    logic reg_wr_en;
  } ctrl_t;

  function automatic logic is_mem_op(input ctrl_t c);
    return c.is_load | c.is_store;
  endfunction

endpackage

// File: rtl/ex_mem_stage_pipe_reg.sv
// Generic pipeline register: load on enable, asynchronous active-low clear to zero.
module pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: latches the ALU result, resolves branch/JAL redirects,
// runs the data-memory handshake and drives forwarding and writeback.
//
//   state    | meaning
//   MEM_IDLE | no outstanding memory request, or one acked in its first cycle
//   MEM_WAIT | load/store request issued, waiting for mem_ack
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_BIT_WIDTH = DEF_DATA_W,
  parameter int ADDR_BIT_WIDTH = DEF_ADDR_W,
  parameter int REG_IDX_WIDTH  = DEF_REG_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ex_valid,
  input  logic [DATA_BIT_WIDTH-1:0] ex_aluOut,
  input  logic                      ex_cmpOut,
  input  logic                      ex_isBranch,
  input  logic                      ex_isJal,
  input  logic                      ex_isLoad,
  input  logic                      ex_isStore,
  input  logic                      ex_regWrEn,
  input  logic [REG_IDX_WIDTH-1:0]  ex_destReg,
  input  logic [DATA_BIT_WIDTH-1:0] ex_storeData,
  input  logic [ADDR_BIT_WIDTH-1:0] ex_pcPlus4,
  input  logic [ADDR_BIT_WIDTH-1:0] ex_brTarget,
  output logic                      stall_o,
  output logic                      redirect_o,
  output logic [ADDR_BIT_WIDTH-1:0] redirect_pc,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_BIT_WIDTH-1:0] mem_addr,
  output logic [DATA_BIT_WIDTH-1:0] mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_BIT_WIDTH-1:0] mem_rdata,
  output logic                      fwd_valid,
  output logic [REG_IDX_WIDTH-1:0]  fwd_reg,
  output logic [DATA_BIT_WIDTH-1:0] fwd_data,
  output logic                      wb_valid,
  output logic                      wb_regWrEn,
  output logic [REG_IDX_WIDTH-1:0]  wb_destReg,
  output logic [DATA_BIT_WIDTH-1:0] wb_data
);

  localparam int DW = DATA_BIT_WIDTH;
  localparam int AW = ADDR_BIT_WIDTH;
  localparam int RW = REG_IDX_WIDTH;
  localparam int MW = 1 + $bits(ctrl_t) + RW + DW + DW + AW;
  localparam int WW = 2 + RW + DW;

  ctrl_t          ex_ctrl;
  logic [MW-1:0]  m_d, m_q;
  logic           m_valid;
  ctrl_t          m_ctrl;
  logic [RW-1:0]  m_dest;
  logic [DW-1:0]  m_alu, m_sdata;
  logic [AW-1:0]  m_pc4;
  logic           m_mem, m_done, taken;
  logic [DW-1:0]  m_result;
  logic [WW-1:0]  wb_d, wb_q;
  mem_state_t     mem_state;

  assign ex_ctrl = '{is_branch: ex_isBranch, is_jal: ex_isJal, is_load: ex_isLoad,
                     is_store: ex_isStore, reg_wr_en: ex_regWrEn};

  // The instruction sitting behind a redirect is squashed as it enters M.
  assign m_d = {ex_valid & ~redirect_o, ex_ctrl, ex_destReg, ex_aluOut, ex_storeData, ex_pcPlus4};

  pipe_reg #(.WIDTH(MW)) u_m_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (~stall_o),
    .d       (m_d),
    .q       (m_q)
  );

  assign {m_valid, m_ctrl, m_dest, m_alu, m_sdata, m_pc4} = m_q;

  assign m_mem     = m_valid & is_mem_op(m_ctrl);
  assign stall_o   = m_mem & ~mem_ack;
  assign mem_req   = m_mem;
  assign mem_we    = m_valid & m_ctrl.is_store;
  assign mem_addr  = AW'(m_alu);
  assign mem_wdata = m_sdata;

  assign fwd_valid = m_valid & m_ctrl.reg_wr_en & ~m_ctrl.is_load;
  assign fwd_reg   = m_dest;
  assign fwd_data  = m_ctrl.is_jal ? DW'(m_pc4) : m_alu;

  always_comb begin
    m_result = m_alu;
    if (m_ctrl.is_load)
      m_result = mem_rdata;
    else if (m_ctrl.is_jal)
      m_result = DW'(m_pc4);
  end

  assign m_done = m_valid & (~is_mem_op(m_ctrl) | mem_ack);

  // On a bubble only the strobes clear; index and data keep their last values.
  assign wb_d = m_done ? {1'b1, m_ctrl.reg_wr_en & ~m_ctrl.is_branch & ~m_ctrl.is_store,
                          m_dest, m_result}
                       : {2'b00, wb_destReg, wb_data};

  pipe_reg #(.WIDTH(WW)) u_wb_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .d       (wb_d),
    .q       (wb_q)
  );

  assign {wb_valid, wb_regWrEn, wb_destReg, wb_data} = wb_q;

  // Stall gating keeps a branch waiting behind a busy load from redirecting early.
  assign taken = ex_valid & ~redirect_o & ~stall_o & ((ex_isBranch & ex_cmpOut) | ex_isJal);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_o  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect_o <= taken;
      if (taken)
        redirect_pc <= ex_brTarget;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_state <= MEM_IDLE;
    end else begin
      case (mem_state)
        MEM_IDLE: if (mem_req && !mem_ack) mem_state <= MEM_WAIT;
        MEM_WAIT: if (mem_ack) mem_state <= MEM_IDLE;
        default:  mem_state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: expected retirements are queued at issue and
// compared as wb_valid strobes; per-scenario tasks check stall/redirect/memory timing.
module tb_ex_mem_stage;

  logic        clk, reset_n;
  logic        ex_valid, ex_cmpOut, ex_isBranch, ex_isJal, ex_isLoad, ex_isStore, ex_regWrEn;
  logic [31:0] ex_aluOut, ex_storeData, ex_pcPlus4, ex_brTarget;
  logic [3:0]  ex_destReg;
  logic        stall_o, redirect_o, mem_req, mem_we, mem_ack;
  logic [31:0] redirect_pc, mem_addr, mem_wdata, mem_rdata;
  logic        fwd_valid, wb_valid, wb_regWrEn;
  logic [3:0]  fwd_reg, wb_destReg;
  logic [31:0] fwd_data, wb_data;

  typedef struct {
    logic        we;
    logic [3:0]  dest;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  ex_mem_stage dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_aluOut(ex_aluOut), .ex_cmpOut(ex_cmpOut),
    .ex_isBranch(ex_isBranch), .ex_isJal(ex_isJal), .ex_isLoad(ex_isLoad),
    .ex_isStore(ex_isStore), .ex_regWrEn(ex_regWrEn), .ex_destReg(ex_destReg),
    .ex_storeData(ex_storeData), .ex_pcPlus4(ex_pcPlus4), .ex_brTarget(ex_brTarget),
    .stall_o(stall_o), .redirect_o(redirect_o), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .wb_valid(wb_valid), .wb_regWrEn(wb_regWrEn), .wb_destReg(wb_destReg), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Retirement monitor: every wb_valid strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && wb_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL wb_unexpected: got wb_valid=1 dest=%0d data=%h, required no retirement",
                 wb_destReg, wb_data);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        if (wb_regWrEn !== e.we || wb_destReg !== e.dest || wb_data !== e.data)
          $display("FAIL wb_retire: got we=%b dest=%0d data=%h, required we=%b dest=%0d data=%h",
                   wb_regWrEn, wb_destReg, wb_data, e.we, e.dest, e.data);
        else
          n_pass++;
      end
    end
  end

  task automatic idle_ex();
    ex_valid = 0; ex_cmpOut = 0; ex_isBranch = 0; ex_isJal = 0; ex_isLoad = 0;
    ex_isStore = 0; ex_regWrEn = 0; ex_destReg = '0; ex_aluOut = '0;
    ex_storeData = '0; ex_pcPlus4 = '0; ex_brTarget = '0;
  endtask

  task automatic drive_ex(input logic br, input logic jal, input logic ld, input logic st,
                          input logic we, input logic cmp, input logic [3:0] dest,
                          input logic [31:0] alu, input logic [31:0] sdata,
                          input logic [31:0] pc4, input logic [31:0] tgt);
    ex_valid = 1; ex_isBranch = br; ex_isJal = jal; ex_isLoad = ld; ex_isStore = st;
    ex_regWrEn = we; ex_cmpOut = cmp; ex_destReg = dest; ex_aluOut = alu;
    ex_storeData = sdata; ex_pcPlus4 = pc4; ex_brTarget = tgt;
  endtask

  task automatic push_exp(input logic we, input logic [3:0] dest, input logic [31:0] data);
    wb_exp_t e;
    e.we = we; e.dest = dest; e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL %s_drain: %0d retirements still pending, required 0", name, sb.size());
    else
      n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 0; mem_ack = 0; mem_rdata = '0;
    idle_ex();
    #1;
    n_checks++;
    if ({stall_o, redirect_o, mem_req, wb_valid, wb_regWrEn, fwd_valid} !== 6'b0 ||
        redirect_pc !== 32'h0 || wb_data !== 32'h0 || mem_addr !== 32'h0 || fwd_data !== 32'h0)
      $display("FAIL reset_outputs: got stall=%b redir=%b req=%b wbv=%b pc=%h wbd=%h, required all 0",
               stall_o, redirect_o, mem_req, wb_valid, redirect_pc, wb_data);
    else
      n_pass++;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_alu_add();
    @(negedge clk);
    drive_ex(0, 0, 0, 0, 1, 0, 4'd3, 32'h5, 32'h0, 32'h0, 32'h0);
    push_exp(1, 4'd3, 32'h5);
    @(negedge clk);
    idle_ex();
    n_checks++;
    if (fwd_valid !== 1'b1 || fwd_reg !== 4'd3 || fwd_data !== 32'h5 || stall_o !== 1'b0)
      $display("FAIL add_fwd: got fwd_valid=%b reg=%0d data=%h stall=%b, required 1/3/5/0",
               fwd_valid, fwd_reg, fwd_data, stall_o);
    else
      n_pass++;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 1'b0 || wb_valid !== 1'b1)
      $display("FAIL add_latency: got stall=%b wb_valid=%b, required 0/1", stall_o, wb_valid);
    else
      n_pass++;
    wait_drain("add");
  endtask

  task automatic test_branch_taken();
    @(negedge clk);
    drive_ex(1, 0, 0, 0, 0, 1, 4'd0, 32'h0, 32'h0, 32'h0, 32'h40);
    push_exp(0, 4'd0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (redirect_o !== 1'b1 || redirect_pc !== 32'h40)
      $display("FAIL beq_redirect: got redirect=%b pc=%h, required 1/00000040", redirect_o, redirect_pc);
    else
      n_pass++;
    drive_ex(0, 0, 0, 0, 1, 0, 4'd7, 32'h99, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    idle_ex();
    n_checks++;
    if (redirect_o !== 1'b0 || fwd_valid !== 1'b0)
      $display("FAIL beq_squash: got redirect=%b fwd_valid=%b, required 0/0", redirect_o, fwd_valid);
    else
      n_pass++;
    repeat (3) @(negedge clk);
    wait_drain("beq");
  endtask

  task automatic test_load_wait();
    @(negedge clk);
    drive_ex(0, 0, 1, 0, 1, 0, 4'd5, 32'h100, 32'h0, 32'h0, 32'h0);
    push_exp(1, 4'd5, 32'hDEADBEEF);
    @(negedge clk);
    idle_ex();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (stall_o !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100)
        $display("FAIL lw_wait_%0d: got stall=%b req=%b we=%b addr=%h, required 1/1/0/00000100",
                 i, stall_o, mem_req, mem_we, mem_addr);
      else
        n_pass++;
      @(negedge clk);
    end
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (stall_o !== 1'b0 || mem_req !== 1'b1)
      $display("FAIL lw_ack: got stall=%b req=%b, required 0/1", stall_o, mem_req);
    else
      n_pass++;
    @(negedge clk);
    mem_ack = 0; mem_rdata = '0;
    n_checks++;
    if (mem_req !== 1'b0 || stall_o !== 1'b0)
      $display("FAIL lw_release: got req=%b stall=%b, required 0/0", mem_req, stall_o);
    else
      n_pass++;
    wait_drain("lw");
  endtask

  task automatic test_store_same_cycle();
    @(negedge clk);
    drive_ex(0, 0, 0, 1, 1, 0, 4'd9, 32'h80, 32'h1234, 32'h0, 32'h0);
    push_exp(0, 4'd9, 32'h80);
    @(negedge clk);
    idle_ex();
    mem_ack = 1;
    #1;
    n_checks++;
    if (stall_o !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b1 ||
        mem_addr !== 32'h80 || mem_wdata !== 32'h1234)
      $display("FAIL sw_req: got stall=%b req=%b we=%b addr=%h wdata=%h, required 0/1/1/80/1234",
               stall_o, mem_req, mem_we, mem_addr, mem_wdata);
    else
      n_pass++;
    @(negedge clk);
    mem_ack = 0;
    n_checks++;
    if (mem_we !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL sw_one_cycle: got we=%b req=%b, required 0/0", mem_we, mem_req);
    else
      n_pass++;
    wait_drain("sw");
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 1'b0 || mem_req !== 1'b0 || wb_valid !== 1'b0)
      $display("FAIL stray_ack: got stall=%b req=%b wb_valid=%b, required 0/0/0",
               stall_o, mem_req, wb_valid);
    else
      n_pass++;
    mem_ack = 0; mem_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    drive_ex(0, 0, 1, 0, 1, 0, 4'd6, 32'h300, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    idle_ex();
    n_checks++;
    if (stall_o !== 1'b1 || mem_req !== 1'b1)
      $display("FAIL rst_pre_wait: got stall=%b req=%b, required 1/1", stall_o, mem_req);
    else
      n_pass++;
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || stall_o !== 1'b0 || wb_valid !== 1'b0 || redirect_o !== 1'b0)
      $display("FAIL rst_async: got req=%b stall=%b wb_valid=%b redir=%b, required 0/0/0/0",
               mem_req, stall_o, wb_valid, redirect_o);
    else
      n_pass++;
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0 || stall_o !== 1'b0)
      $display("FAIL rst_release: got req=%b stall=%b, required 0/0", mem_req, stall_o);
    else
      n_pass++;
  endtask

  task automatic test_jal();
    @(negedge clk);
    drive_ex(0, 1, 0, 0, 1, 0, 4'd15, 32'h777, 32'h0, 32'h24, 32'h200);
    push_exp(1, 4'd15, 32'h24);
    @(negedge clk);
    idle_ex();
    n_checks++;
    if (redirect_o !== 1'b1 || redirect_pc !== 32'h200 || fwd_valid !== 1'b1 ||
        fwd_reg !== 4'd15 || fwd_data !== 32'h24)
      $display("FAIL jal_redirect: got redir=%b pc=%h fwd=%b/%0d/%h, required 1/200/1/15/24",
               redirect_o, redirect_pc, fwd_valid, fwd_reg, fwd_data);
    else
      n_pass++;
    wait_drain("jal");
  endtask

  task automatic test_branch_during_stall();
    @(negedge clk);
    drive_ex(0, 0, 1, 0, 1, 0, 4'd2, 32'h140, 32'h0, 32'h0, 32'h0);
    push_exp(1, 4'd2, 32'h0000CAFE);
    @(negedge clk);
    drive_ex(1, 0, 0, 0, 0, 1, 4'd0, 32'h0, 32'h0, 32'h0, 32'h300);
    push_exp(0, 4'd0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (redirect_o !== 1'b0 || stall_o !== 1'b1)
      $display("FAIL br_stalled: got redir=%b stall=%b, required 0/1", redirect_o, stall_o);
    else
      n_pass++;
    mem_ack = 1; mem_rdata = 32'h0000CAFE;
    @(negedge clk);
    mem_ack = 0; mem_rdata = '0;
    idle_ex();
    n_checks++;
    if (redirect_o !== 1'b1 || redirect_pc !== 32'h300)
      $display("FAIL br_after_stall: got redir=%b pc=%h, required 1/00000300", redirect_o, redirect_pc);
    else
      n_pass++;
    @(negedge clk);
    n_checks++;
    if (redirect_o !== 1'b0)
      $display("FAIL br_one_cycle: got redir=%b, required 0", redirect_o);
    else
      n_pass++;
    wait_drain("brstall");
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[4];
    vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002; vals[2] = 32'h3333_0003;
    vals[3] = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_ex(0, 0, 0, 0, 1, 0, 4'(i + 8), vals[i], 32'h0, 32'h0, 32'h0);
      push_exp(1, 4'(i + 8), vals[i]);
    end
    @(negedge clk);
    drive_ex(1, 0, 0, 0, 0, 0, 4'd1, 32'h11, 32'h0, 32'h0, 32'h500);
    push_exp(0, 4'd1, 32'h11);
    @(negedge clk);
    idle_ex();
    n_checks++;
    if (redirect_o !== 1'b0)
      $display("FAIL bne_not_taken: got redir=%b, required 0", redirect_o);
    else
      n_pass++;
    wait_drain("b2b");
  endtask

  initial begin
    test_reset();
    test_alu_add();
    test_branch_taken();
    test_load_wait();
    test_store_same_cycle();
    test_stray_ack();
    test_reset_in_wait();
    test_jal();
    test_branch_during_stall();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
